// File: rtl/div_restore16.sv
// Sequential 16-bit unsigned restoring divider with start/busy/done handshake.
// One trial subtraction per cycle; quotient/remainder land 17 cycles after start.
//
// state | meaning
// IDLE  | waiting for start; results from the previous operation are held
// RUN   | 16 shift/subtract iterations, one per cycle
// DONE  | results valid, one-cycle done pulse
module div_restore16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] t;
  logic             borrow;

  // When no borrow, S - Dv < Dv, so the 16-bit truncated difference is exact.
  assign s      = {r_q, q_q[WIDTH-1]};
  assign borrow = (s < {1'b0, dv_q});
  assign t      = s[WIDTH-1:0] - dv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            dv_d    = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (borrow) begin
          r_d = s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = t;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          quo_d   = q_d;
          rem_d   = r_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restore16.sv
// Directed and random checks for div_restore16: latency, handshake, results,
// divide-by-zero, ignored starts and mid-operation reset.
module tb_div_restore16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_q = '0;
  logic [15:0] last_r = '0;

  div_restore16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one division and follow it to done with a bounded wait.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    int n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, " busy"}, busy, 1);
      chk({tag, " hold_q"}, quotient, last_q);
      chk({tag, " hold_r"}, remainder, last_r);
      tick();
      n++;
    end
    chk({tag, " latency"}, n, (b == 16'd0) ? 1 : 17);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, div_by_zero, edbz);
    last_q = eq;
    last_r = er;
    tick();
    chk({tag, " done_pulse_end"}, done, 0);
  endtask

  initial begin
    int n;
    int ndone;
    logic [15:0] a, b;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    run_op("100/7",     16'd100,   16'd7,     16'd14,    16'd2,     1'b0);
    run_op("ffff/1",    16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0);
    run_op("ffff/ffff", 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0);
    run_op("5/9",       16'd5,     16'd9,     16'd0,     16'd5,     1'b0);
    run_op("8000/8001", 16'h8000,  16'h8001,  16'd0,     16'h8000,  1'b0);
    run_op("1234/0",    16'h1234,  16'd0,     16'hFFFF,  16'h1234,  1'b1);
    run_op("10/3",      16'd10,    16'd3,     16'd3,     16'd1,     1'b0);
    run_op("60000/251", 16'd60000, 16'd251,   16'd239,   16'd11,    1'b0);

    // Second start during RUN is dropped.
    dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    dividend = 16'd7; divisor = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign busy", busy, 1);
    chk("ign hold_q", quotient, last_q);
    chk("ign hold_r", remainder, last_r);
    n = 6;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ign latency", n, 17);
    chk("ign quotient", quotient, 100);
    chk("ign remainder", remainder, 0);
    last_q = 16'd100; last_r = 16'd0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("ign single_done", ndone, 0);

    // Reset in the middle of a division.
    dividend = 16'd50000; divisor = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst dbz", div_by_zero, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    last_q = '0; last_r = '0;
    run_op("9/2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0);

    // start held high: re-accepted in the first IDLE cycle after DONE.
    dividend = 16'd20; divisor = 16'd0; start = 1'b1;
    tick();
    chk("b2b done0", done, 1);
    tick();
    chk("b2b idle", done, 0);
    tick();
    chk("b2b done1", done, 1);
    chk("b2b quotient", quotient, 16'hFFFF);
    chk("b2b remainder", remainder, 16'd20);
    start = 1'b0;
    tick();
    last_q = 16'hFFFF; last_r = 16'd20;

    for (int k = 0; k < 2000; k++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 15);
      if (b == 16'd0) run_op("rand", a, b, 16'hFFFF, a, 1'b1);
      else            run_op("rand", a, b, a / b, a % b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
